// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result drain: FSM encoding, default output
// width and saturation bounds derived from an output width.
package mac_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam int OUT_WIDTH_DEF = 8;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint SAT_MAX_DEF = sat_max(OUT_WIDTH_DEF);
    localparam longint SAT_MIN_DEF = sat_min(OUT_WIDTH_DEF);

endpackage

// File: rtl/acc_requant.sv
// Combinational requantizer: optional round-half-up, arithmetic right shift,
// then signed saturation to OUT_WIDTH.
module acc_requant
    import mac_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int ROUND_EN  = 1
) (
    input  logic signed [ACC_WIDTH-1:0] x,
    input  logic        [4:0]           shift,
    output logic        [OUT_WIDTH-1:0] y,
    output logic                        sat
);

    // One guard bit so the rounding add of a near-max accumulator cannot wrap.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] Y_MAX = EW'(sat_max(OUT_WIDTH));
    localparam logic signed [EW-1:0] Y_MIN = EW'(sat_min(OUT_WIDTH));

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] shd;

    always_comb begin
        ext = {x[ACC_WIDTH-1], x};
        rnd = '0;
        if (ROUND_EN != 0 && shift != 5'd0)
            rnd = EW'(1) << (shift - 5'd1);
        shd = (ext + rnd) >>> shift;
        y   = shd[OUT_WIDTH-1:0];
        sat = 1'b0;
        if (shd > Y_MAX) begin
            y   = Y_MAX[OUT_WIDTH-1:0];
            sat = 1'b1;
        end else if (shd < Y_MIN) begin
            y   = Y_MIN[OUT_WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/mac_result_drain.sv
// Snapshots the MAC accumulator array on start and streams requantized
// elements row-major over valid/ready, one beat per cycle when unstalled.
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int MAC_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int ROUND_EN  = 1,
    localparam int N    = MAC_WIDTH * MAC_WIDTH,
    localparam int RC_W = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*ACC_WIDTH-1:0] c_acc_flat,
    input  logic                   start,
    input  logic [4:0]             shift,
    output logic                   start_ready,
    output logic                   captured,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic [RC_W-1:0]        out_row,
    output logic [RC_W-1:0]        out_col,
    output logic                   out_last,
    output logic                   done
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [0:0]                      state;
    logic [IDX_W-1:0]                idx, idx_next;
    logic [RC_W-1:0]                 row, col;
    logic [4:0]                      shift_q, shift_sel;
    logic [N-1:0][ACC_WIDTH-1:0]     acc_arr, snap;
    logic signed [ACC_WIDTH-1:0]     elem;
    logic [OUT_WIDTH-1:0]            rq_y;
    logic                            rq_sat;
    logic                            accept, hs, at_last, advance;

    assign acc_arr = c_acc_flat;

    assign accept  = (state == ST_IDLE) & start;
    assign hs      = out_valid & out_ready;
    assign at_last = (idx == IDX_W'(N - 1));
    assign advance = hs & ~at_last;

    assign idx_next = accept  ? '0
                    : advance ? idx + 1'b1
                    : idx;

    // Element 0 is requantized straight from the live inputs on the capture
    // edge, since the snapshot is only being written on that same edge.
    assign elem      = (state == ST_IDLE) ? acc_arr[0] : snap[idx_next];
    assign shift_sel = (state == ST_IDLE) ? shift : shift_q;

    acc_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .ROUND_EN  (ROUND_EN)
    ) u_requant (
        .x     (elem),
        .shift (shift_sel),
        .y     (rq_y),
        .sat   (rq_sat)
    );

    always_ff @(posedge clk) begin
        if (accept)
            snap <= acc_arr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            row      <= '0;
            col      <= '0;
            shift_q  <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
            captured <= 1'b0;
        end else begin
            captured <= accept;
            if (accept) begin
                state   <= ST_STREAM;
                shift_q <= shift;
                row     <= '0;
                col     <= '0;
            end else if (hs && at_last) begin
                state <= ST_IDLE;
            end else if (advance) begin
                if (col == RC_W'(MAC_WIDTH - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            idx <= idx_next;
            if (accept || advance) begin
                out_data <= rq_y;
                out_sat  <= rq_sat;
            end
        end
    end

    assign start_ready = (state == ST_IDLE);
    assign out_valid   = (state == ST_STREAM);
    assign out_last    = (state == ST_STREAM) & at_last;
    assign out_row     = row;
    assign out_col     = col;
    assign done        = hs & at_last;

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain: row-major streaming, backpressure,
// rounding/saturation, snapshot isolation, start handling and mid-stream reset.
module tb_mac_result_drain;

    localparam int MW = 8;
    localparam int N  = MW * MW;
    localparam int AW = 32;
    localparam int OW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*AW-1:0] c_acc_flat = '0;
    logic            start = 1'b0;
    logic [4:0]      shift = '0;
    logic            out_ready = 1'b0;
    logic            start_ready, captured, out_valid, out_sat, out_last, done;
    logic [OW-1:0]   out_data;
    logic [2:0]      out_row, out_col;

    int errs = 0;
    int checks = 0;

    logic [AW-1:0] src   [N];
    logic [OW-1:0] exp_d [N];
    logic          exp_s [N];

    mac_result_drain #(
        .MAC_WIDTH (MW),
        .ACC_WIDTH (AW),
        .OUT_WIDTH (OW),
        .ROUND_EN  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .c_acc_flat  (c_acc_flat),
        .start       (start),
        .shift       (shift),
        .start_ready (start_ready),
        .captured    (captured),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_src();
        for (int k = 0; k < N; k++) c_acc_flat[k*AW +: AW] = src[k];
    endtask

    task automatic set_identity();
        for (int k = 0; k < N; k++) begin
            src[k] = AW'(k); exp_d[k] = OW'(k); exp_s[k] = 1'b0;
        end
    endtask

    // Runs one tile. stop_at >= 0 returns as soon as that beat is presented.
    task automatic run_tile(input logic [4:0] sh, input bit bp, input bit hold_start,
                            input bit corrupt, input int stop_at);
        int k = 0;
        int cyc = 0;
        int caps = 0;
        bit stalled = 0;
        logic [OW-1:0] h_d;
        logic h_s, h_l;
        logic [2:0] h_r, h_c;
        @(negedge clk);
        load_src();
        shift = sh;
        start = 1'b1;
        #1 chk("start_ready_idle", start_ready, 1);
        while (k < N) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) start = 1'b0;
            if (corrupt && cyc == 1)
                for (int j = 0; j < N; j++) c_acc_flat[j*AW +: AW] = 32'hDEAD0000;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == stop_at) out_ready = 1'b0;
            #1;
            caps += int'(captured);
            chk("captured_once", captured, (cyc == 1) ? 1 : 0);
            chk("out_valid", out_valid, 1);
            chk("start_ready_busy", start_ready, 0);
            if (stalled) begin
                chk("stall_data", out_data, h_d);
                chk("stall_sat", out_sat, h_s);
                chk("stall_row", out_row, h_r);
                chk("stall_col", out_col, h_c);
                chk("stall_last", out_last, h_l);
            end
            if (k == stop_at) return;
            if (out_valid && out_ready) begin
                chk($sformatf("data[%0d]", k), out_data, exp_d[k]);
                chk($sformatf("sat[%0d]", k), out_sat, exp_s[k]);
                chk($sformatf("row[%0d]", k), out_row, k / MW);
                chk($sformatf("col[%0d]", k), out_col, k % MW);
                chk($sformatf("last[%0d]", k), out_last, (k == N - 1) ? 1 : 0);
                chk($sformatf("done[%0d]", k), done, (k == N - 1) ? 1 : 0);
                k++;
                stalled = 0;
            end else begin
                chk("done_on_stall", done, 0);
                stalled = 1;
                h_d = out_data; h_s = out_sat; h_r = out_row; h_c = out_col; h_l = out_last;
            end
            if (cyc > 2000) begin
                chk("timeout_beats", k, N);
                break;
            end
        end
        chk("captured_pulses", caps, 1);
        if (!hold_start) start = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_captured", captured, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic stream, then the same sequence under random backpressure.
        set_identity();
        run_tile(5'd0, 0, 0, 0, -1);
        run_tile(5'd0, 1, 0, 0, -1);

        // Rounding and saturation at shift 4: most elements are 16k -> k.
        for (int k = 0; k < N; k++) begin
            src[k] = AW'(k * 16); exp_d[k] = OW'(k); exp_s[k] = 1'b0;
        end
        src[0] = 32'd24;       exp_d[0] = 8'd2;
        src[1] = AW'(-24);     exp_d[1] = 8'hFF;
        src[2] = 32'd5000;     exp_d[2] = 8'h7F; exp_s[2] = 1'b1;
        src[3] = AW'(-5000);   exp_d[3] = 8'h80; exp_s[3] = 1'b1;
        src[4] = 32'd23;       exp_d[4] = 8'd1;
        src[5] = AW'(-25);     exp_d[5] = 8'hFE;
        run_tile(5'd4, 0, 0, 0, -1);

        // Shift 31: the rounding add must not overflow the accumulator width.
        for (int k = 0; k < N; k++) begin
            src[k] = '0; exp_d[k] = '0; exp_s[k] = 1'b0;
        end
        src[0] = 32'h7FFFFFFF; exp_d[0] = 8'd1;
        src[1] = 32'h80000000; exp_d[1] = 8'hFF;
        src[2] = 32'h3FFFFFFF; exp_d[2] = 8'd0;
        src[3] = 32'd5000;     exp_d[3] = 8'd0;
        run_tile(5'd31, 0, 0, 0, -1);

        // Inputs overwritten the cycle after capture must not reach the stream.
        set_identity();
        run_tile(5'd0, 1, 0, 1, -1);

        // start held through a stream, then a back-to-back tile with new data.
        run_tile(5'd0, 0, 1, 0, -1);
        for (int k = 0; k < N; k++) begin
            src[k] = AW'((N - k) * 4); exp_d[k] = OW'(N - k); exp_s[k] = 1'b0;
        end
        run_tile(5'd2, 0, 0, 0, -1);

        // Async reset with beat 20 on the bus, then a clean restart.
        set_identity();
        run_tile(5'd0, 0, 0, 0, 20);
        chk("pre_rst_data", out_data, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_start_ready", start_ready, 1);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_row", out_row, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_start_ready", start_ready, 1);
        chk("post_rst_done", done, 0);
        run_tile(5'd0, 0, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Downstream stage of the MAC array. On a start command it snapshots all MAC_WIDTH x MAC_WIDTH accumulators in one cycle.
- It then streams the results out row-major, one element per beat, over a valid/ready interface.
- Each element is requantized to OUT_WIDTH: rounded arithmetic right shift followed by signed saturation.
- The snapshot frees the array to clear and start the next tile while the drain runs.

Parameters:
- MAC_WIDTH, 8, array dimension; element count N = MAC_WIDTH*MAC_WIDTH.
- ACC_WIDTH, 32, accumulator width, signed two's complement.
- OUT_WIDTH, 8, output element width, signed.
- ROUND_EN, 1, 1 = round-half-up before the shift; 0 = truncate.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- c_acc_flat  in  N*ACC_WIDTH  accumulators; C[i][j] at bits [(i*MAC_WIDTH+j)*ACC_WIDTH +: ACC_WIDTH].
- start  in  1  request capture and drain.
- shift  in  5  right-shift amount, 0..31, sampled with start.
- start_ready  out  1  high in IDLE only.
- captured  out  1  one-cycle pulse the cycle after start is accepted; the array may be cleared from then on.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_WIDTH  requantized element.
- out_sat  out  1  element was saturated.
- out_row  out  clog2(MAC_WIDTH)  row index i of the beat.
- out_col  out  clog2(MAC_WIDTH)  column index j of the beat.
- out_last  out  1  beat is element N-1.
- done  out  1  one-cycle pulse on the final handshake.

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous and active-low on rst_n.
  - Reset values: state IDLE, idx=0, start_ready=1, out_valid=0, out_data=0, out_sat=0, out_row=0, out_col=0, out_last=0, captured=0, done=0.
  - The snapshot array is not reset; its contents are don't-care until the first capture.
- FSM, IDLE / STREAM:
  - IDLE: start_ready=1. When start=1 the block loads the snapshot from c_acc_flat, latches shift, sets idx=0 and moves to STREAM.
  - STREAM entry: the next cycle has out_valid=1, element 0 on the outputs and captured=1 for exactly that cycle.
  - STREAM: a handshake is out_valid & out_ready. If the handshake is on idx<N-1, increment idx and present element idx+1 in the very next cycle (no bubbles, full throughput).
  - Last beat: a handshake with out_last=1 returns to IDLE; done=1 that cycle; out_valid=0 next cycle.
  - start is ignored outside IDLE. The earliest re-accept is the cycle after done, so back-to-back tiles have a one-cycle gap.
- Output stability:
  - While out_valid=1 and out_ready=0, out_data, out_sat, out_row, out_col and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
- Requant, per element x, signed ACC_WIDTH:
  - Rounding: if ROUND_EN and shift>0, y = (x + (1<<(shift-1))) >>> shift, computed at ACC_WIDTH+1 bits so the add cannot overflow. Otherwise y = x >>> shift.
  - Saturation: if y > 2^(OUT_WIDTH-1)-1, output the max and set out_sat=1. If y < -2^(OUT_WIDTH-1), output the min and set out_sat=1. Otherwise output the low OUT_WIDTH bits with out_sat=0.
  - out_data and out_sat are registered: the requant is computed from snapshot[idx_next] and the result is loaded on the same edge as idx.
- Capture semantics: changes on c_acc_flat after the capture edge never affect the stream, including a clear_acc on the capture+1 cycle.
- Reset mid-stream: the stream aborts immediately, outputs take reset values, and no done pulse is generated.

Decomposition:
- Shared package mac_pkg:
  - FSM state encoding (ST_IDLE, ST_STREAM).
  - Default OUT_WIDTH.
  - Saturation-bound helper constants derived from OUT_WIDTH.
- Sub-module acc_requant, combinational:
  - Inputs: x[ACC_WIDTH], shift[5].
  - Outputs: y[OUT_WIDTH], sat.
  - Parameterised by ACC_WIDTH, OUT_WIDTH and ROUND_EN; unit-tested standalone.
- Top level holds the FSM, idx counter, snapshot registers, element mux and output registers.

Test Plan:
- Basic stream: MAC_WIDTH=8, C[i][j]=i*8+j, shift=0, out_ready=1 constantly. Expect 64 beats in consecutive cycles with out_data 0..63. out_row/out_col follow row-major order. out_last and done on beat 63 only. captured pulses once.
- Backpressure: toggle out_ready pseudo-randomly. Expect no beat lost or duplicated, and outputs stable during every stall. Sequence must be identical to the basic-stream case.
- Rounding and saturation, shift=4, ROUND_EN=1:
  - x=24 gives 2, rounded up from 1.5.
  - x=-24 gives -1, half-up.
  - x=5000 gives 127 with out_sat=1.
  - x=-5000 gives -128 with out_sat=1.
  - Also check x=0x7FFFFFFF at shift=31 gives 1 (no overflow at ACC_WIDTH+1).
- Snapshot isolation: change all c_acc_flat to 0xDEAD0000 on the cycle after capture. Expect the stream to still carry the original values.
- Start handling:
  - start held high throughout STREAM is ignored; start_ready=0 during STREAM.
  - After done, start is re-accepted the next cycle and a second tile with new data streams correctly.
- Reset mid-stream: assert rst_n=0 asynchronously at beat 20. Expect out_valid=0 immediately, no done pulse and start_ready=1 after release. The next start streams from element 0.
